// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and width helpers for the parametrised FIFO.
//   FIFO_MODE_STD / FIFO_MODE_FWFT select the read-data behaviour.
//   ptr_width(depth) gives the pointer (address) width for a depth.
//   cnt_width(depth) gives the occupancy width (holds 0..depth inclusive).
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Pointer width for a power-of-two depth; never less than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy width: one extra bit so that count == depth is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x WIDTH register array storing the FIFO words.
// Ports:
//   clk         in   write clock
//   write_en    in   store write_data at write_addr on the rising edge
//   write_addr  in   write address
//   write_data  in   word to store
//   read_addr   in   asynchronous read address
//   read_data   out  mem[read_addr], combinational
// Contents are not reset; the FIFO's pointers and count define validity.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = ptr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [WIDTH-1:0]  write_data,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [WIDTH-1:0]  read_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    assign read_data = mem[read_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with standard or
// first-word-fall-through read, occupancy count, almost flags and
// registered over/underflow error pulses.
// Ports:
//   clk           in   sole clock, rising edge
//   rst           in   synchronous active-low reset
//   write_en      in   write request
//   write_data    in   word to write
//   read_en       in   read (pop) request
//   read_data     out  STD: register loaded on each accepted read;
//                      FWFT: head word while not empty, 0 while empty
//   full, empty   out  count == DEPTH / count == 0 (registered)
//   almost_full   out  count >= AF_THRESH (registered)
//   almost_empty  out  count <= AE_THRESH (registered)
//   count         out  occupancy 0..DEPTH (registered)
//   write_error   out  one-cycle pulse: write rejected on the previous edge
//   read_error    out  one-cycle pulse: read rejected on the previous edge
//
// Handshake: write_en/read_en are requests sampled every rising edge.
// A read is accepted when the FIFO is not empty; a write is accepted when
// the FIFO is not full, or when it is full and a read is accepted on the
// same edge. A rejected request changes no state and raises its error flag
// for the following cycle only.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = FIFO_MODE_STD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   write_en,
    input  logic [WIDTH-1:0]       write_data,
    input  logic                   read_en,
    output logic [WIDTH-1:0]       read_data,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   write_error,
    output logic                   read_error
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_next;
    logic             full_q;
    logic             empty_q;
    logic             af_q;
    logic             ae_q;
    logic             write_error_q;
    logic             read_error_q;
    logic             rd_ok;
    logic             wr_ok;
    logic [WIDTH-1:0] mem_data;

    // Accept decisions use registered flags only, so a write into a full
    // FIFO can ride on a same-edge read without a combinational loop.
    always_comb begin
        rd_ok = read_en & ~empty_q;
        wr_ok = write_en & (~full_q | rd_ok);
    end

    always_comb begin
        count_next = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count_q + 1'b1;
            2'b01:   count_next = count_q - 1'b1;
            default: count_next = count_q;
        endcase
    end

    fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk        (clk),
        .write_en   (wr_ok),
        .write_addr (wr_ptr),
        .write_data (write_data),
        .read_addr  (rd_ptr),
        .read_data  (mem_data)
    );

    // Flags are computed from count_next so they reflect post-edge state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            af_q          <= 1'b0;
            ae_q          <= 1'b1;
            write_error_q <= 1'b0;
            read_error_q  <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q       <= count_next;
            full_q        <= (count_next == DEPTH_C);
            empty_q       <= (count_next == '0);
            af_q          <= (count_next >= AF_C);
            ae_q          <= (count_next <= AE_C);
            write_error_q <= write_en & ~wr_ok;
            read_error_q  <= read_en & ~rd_ok;
        end
    end

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // Head word is shown directly; forced to 0 while empty so the
            // output is well defined after reset.
            assign read_data = empty_q ? '0 : mem_data;
        end else begin : g_std
            logic [WIDTH-1:0] rd_q;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    rd_q <= '0;
                end else if (rd_ok) begin
                    rd_q <= mem_data;
                end
            end
            assign read_data = rd_q;
        end
    endgenerate

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign write_error  = write_error_q;
    assign read_error   = read_error_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: one standard-mode and one FWFT
// instance at default size, hand-computed expected values.
module tb_fifo_sync_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // standard-mode instance signals
    logic             s_we = 1'b0;
    logic [WIDTH-1:0] s_wd = '0;
    logic             s_re = 1'b0;
    logic [WIDTH-1:0] s_rd;
    logic             s_full, s_empty, s_af, s_ae, s_werr, s_rerr;
    logic [CW-1:0]    s_count;

    // FWFT instance signals
    logic             f_we = 1'b0;
    logic [WIDTH-1:0] f_wd = '0;
    logic             f_re = 1'b0;
    logic [WIDTH-1:0] f_rd;
    logic             f_full, f_empty, f_af, f_ae, f_werr, f_rerr;
    logic [CW-1:0]    f_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_sync_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0)) dut_std (
        .clk          (clk),
        .rst          (rst),
        .write_en     (s_we),
        .write_data   (s_wd),
        .read_en      (s_re),
        .read_data    (s_rd),
        .full         (s_full),
        .empty        (s_empty),
        .almost_full  (s_af),
        .almost_empty (s_ae),
        .count        (s_count),
        .write_error  (s_werr),
        .read_error   (s_rerr)
    );

    fifo_sync_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1)) dut_fwft (
        .clk          (clk),
        .rst          (rst),
        .write_en     (f_we),
        .write_data   (f_wd),
        .read_en      (f_re),
        .read_data    (f_rd),
        .full         (f_full),
        .empty        (f_empty),
        .almost_full  (f_af),
        .almost_empty (f_ae),
        .count        (f_count),
        .write_error  (f_werr),
        .read_error   (f_rerr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic std_op(input logic we, input logic [WIDTH-1:0] wd, input logic re);
        s_we = we;
        s_wd = wd;
        s_re = re;
        tick();
        s_we = 1'b0;
        s_re = 1'b0;
    endtask

    task automatic fwft_op(input logic we, input logic [WIDTH-1:0] wd, input logic re);
        f_we = we;
        f_wd = wd;
        f_re = re;
        tick();
        f_we = 1'b0;
        f_re = 1'b0;
    endtask

    // Watchdog: the sequence is fixed-length, this only guards a stuck sim.
    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset ----------------
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        check("rst_count", 32'(s_count), 0);
        check("rst_empty", 32'(s_empty), 1);
        check("rst_full", 32'(s_full), 0);
        check("rst_ae", 32'(s_ae), 1);
        check("rst_af", 32'(s_af), 0);
        check("rst_rdata", 32'(s_rd), 0);
        check("rst_werr", 32'(s_werr), 0);
        check("rst_rerr", 32'(s_rerr), 0);
        check("rst_f_empty", 32'(f_empty), 1);

        // ---------------- fill 0x01..0x10 ----------------
        for (int k = 1; k <= 16; k++) begin
            std_op(1'b1, 8'(k), 1'b0);
            check("fill_count", 32'(s_count), 32'(k));
            check("fill_af", 32'(s_af), (k >= 12) ? 1 : 0);
            check("fill_ae", 32'(s_ae), (k <= 2) ? 1 : 0);
            check("fill_full", 32'(s_full), (k == 16) ? 1 : 0);
            check("fill_empty", 32'(s_empty), 0);
            check("fill_werr", 32'(s_werr), 0);
        end
        std_op(1'b1, 8'h99, 1'b0);
        check("ovf_werr", 32'(s_werr), 1);
        check("ovf_count", 32'(s_count), 16);
        std_op(1'b0, 8'h00, 1'b0);
        check("ovf_werr_clear", 32'(s_werr), 0);

        // ---------------- drain ----------------
        for (int k = 1; k <= 16; k++) begin
            std_op(1'b0, 8'h00, 1'b1);
            check("drain_rdata", 32'(s_rd), 32'(k));
            check("drain_count", 32'(s_count), 32'(16 - k));
            check("drain_rerr", 32'(s_rerr), 0);
        end
        check("drain_empty", 32'(s_empty), 1);
        std_op(1'b0, 8'h00, 1'b1);
        check("udf_rerr", 32'(s_rerr), 1);
        check("udf_rdata_hold", 32'(s_rd), 32'h10);
        check("udf_count", 32'(s_count), 0);
        std_op(1'b0, 8'h00, 1'b0);
        check("udf_rerr_clear", 32'(s_rerr), 0);

        // ---------------- full throughput at full ----------------
        for (int k = 1; k <= 16; k++) std_op(1'b1, 8'(k), 1'b0);
        check("refill_full", 32'(s_full), 1);
        for (int i = 0; i < 8; i++) begin
            std_op(1'b1, 8'(8'hA0 + i), 1'b1);
            check("tput_rdata", 32'(s_rd), 32'(i + 1));
            check("tput_count", 32'(s_count), 16);
            check("tput_werr", 32'(s_werr), 0);
            check("tput_rerr", 32'(s_rerr), 0);
        end
        // remaining order proves the write pointer wrapped onto slots 0..7
        for (int k = 9; k <= 16; k++) begin
            std_op(1'b0, 8'h00, 1'b1);
            check("wrap_rdata_old", 32'(s_rd), 32'(k));
        end
        for (int i = 0; i < 8; i++) begin
            std_op(1'b0, 8'h00, 1'b1);
            check("wrap_rdata_new", 32'(s_rd), 32'(8'hA0 + i));
        end
        check("wrap_empty", 32'(s_empty), 1);

        // ---------------- write+read at empty ----------------
        std_op(1'b1, 8'h55, 1'b1);
        check("we_re_empty_werr", 32'(s_werr), 0);
        check("we_re_empty_rerr", 32'(s_rerr), 1);
        check("we_re_empty_count", 32'(s_count), 1);
        std_op(1'b0, 8'h00, 1'b1);
        check("we_re_empty_rdata", 32'(s_rd), 32'h55);
        check("we_re_empty_count2", 32'(s_count), 0);
        check("we_re_empty_rerr2", 32'(s_rerr), 0);

        // ---------------- mid-operation reset ----------------
        for (int k = 0; k < 5; k++) std_op(1'b1, 8'(8'h11 + k), 1'b0);
        check("pre_rst_count", 32'(s_count), 5);
        rst = 1'b0;
        std_op(1'b1, 8'h77, 1'b0);
        rst = 1'b1;
        check("mrst_count", 32'(s_count), 0);
        check("mrst_empty", 32'(s_empty), 1);
        check("mrst_full", 32'(s_full), 0);
        check("mrst_werr", 32'(s_werr), 0);
        check("mrst_rerr", 32'(s_rerr), 0);
        check("mrst_rdata", 32'(s_rd), 0);
        std_op(1'b1, 8'h21, 1'b0);
        std_op(1'b1, 8'h22, 1'b0);
        check("post_rst_count", 32'(s_count), 2);
        std_op(1'b0, 8'h00, 1'b1);
        check("post_rst_rd0", 32'(s_rd), 32'h21);
        std_op(1'b0, 8'h00, 1'b1);
        check("post_rst_rd1", 32'(s_rd), 32'h22);
        check("post_rst_empty", 32'(s_empty), 1);

        // ---------------- FWFT ----------------
        fwft_op(1'b1, 8'h3C, 1'b0);
        check("fwft_show", 32'(f_rd), 32'h3C);
        check("fwft_count", 32'(f_count), 1);
        check("fwft_empty0", 32'(f_empty), 0);
        fwft_op(1'b0, 8'h00, 1'b0);
        check("fwft_hold", 32'(f_rd), 32'h3C);
        fwft_op(1'b0, 8'h00, 1'b1);
        check("fwft_pop_empty", 32'(f_empty), 1);
        check("fwft_pop_ae", 32'(f_ae), 1);
        check("fwft_pop_count", 32'(f_count), 0);
        check("fwft_pop_rerr", 32'(f_rerr), 0);
        fwft_op(1'b1, 8'h41, 1'b0);
        fwft_op(1'b1, 8'h42, 1'b0);
        check("fwft_head0", 32'(f_rd), 32'h41);
        fwft_op(1'b0, 8'h00, 1'b1);
        check("fwft_head1", 32'(f_rd), 32'h42);
        check("fwft_count1", 32'(f_count), 1);
        fwft_op(1'b0, 8'h00, 1'b1);
        check("fwft_empty_end", 32'(f_empty), 1);
        fwft_op(1'b0, 8'h00, 1'b1);
        check("fwft_udf_rerr", 32'(f_rerr), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
